c7bifu_dec_ilk: RTL

//  Decode-stage issue interlock and scoreboard. Sits beside c7bifu_dec.
//  - Tracks GPR writes still pending from long-latency ops (LSU loads, pipelined MUL).
//  - Drives the decoder stall so RAW/WAW-dependent or serialising instructions are held in D.
//  - Sequences CSR/ERTN/exception ops so they issue only once the machine has drained.

---
 rtl/c7bifu_dec_ilk.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/c7bifu_dec_ilk.sv
// c7bifu_dec_ilk: decode-stage issue interlock and GPR write scoreboard.
// Tracks GPR writes still owed by an outstanding LSU op and by in-flight
// pipelined MULs, stalls dependent or serialising instructions in D, and
// sequences serialising ops so they only issue once the machine has drained.
//
// Build option: define C7B_ILK_LSU_OVERLAP_EN to let independent, non-LSU,
// non-serialising ops issue while a load is outstanding; the DRAIN bubble
// after load completion is then skipped.
module c7bifu_dec_ilk #(
    parameter int unsigned MUL_LAT = 2,   // MUL issue-to-writeback latency (1..4)
    parameter int unsigned LSU_TMO = 255  // LSU outstanding cycles before timeout flag
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        exu_stall,
    input  logic        dec_inst_vld_d,
    input  logic [4:0]  dec_rs1_d,
    input  logic [4:0]  dec_rs2_d,
    input  logic [4:0]  dec_rd_d,
    input  logic        dec_wen_d,
    input  logic        dec_lsu_vld_d,
    input  logic        dec_mul_vld_d,
    input  logic        dec_ser_d,
    input  logic        lsu_ifu_done,
    output logic        ilk_stall,
    output logic        ilk_issue,
    output logic [31:0] ilk_pend,
    output logic        ilk_busy,
    output logic        ilk_lsu_tmo
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LSU_WAIT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [7:0] TMO_CNT = 8'(LSU_TMO);

    state_t                    state_q, state_d;
    logic [4:0]                lsu_rd_q, lsu_rd_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      tmo_q, tmo_d;
    logic [MUL_LAT-1:0]        mul_vld_q, mul_vld_d;
    logic [MUL_LAT-1:0][4:0]   mul_rd_q, mul_rd_d;

    logic [31:0] pend_lsu;
    logic [31:0] pend_mul;
    logic [31:0] pend;
    logic        mul_any;
    logic        hazard;
    logic        fsm_ok;
    logic        issue;
    logic [4:0]  wr_rd;
    logic [7:0]  cnt_inc;

    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        reg_onehot = 32'h1 << r;
    endfunction

    // Destination actually written by the op in D; r0 writes are dropped.
    assign wr_rd = (dec_wen_d && (dec_rd_d != 5'd0)) ? dec_rd_d : 5'd0;

    // Pending-write mask from the outstanding load and every live MUL slot.
    always_comb begin
        pend_mul = '0;
        for (int unsigned i = 0; i < MUL_LAT; i++) begin
            if (mul_vld_q[i]) begin
                pend_mul = pend_mul | reg_onehot(mul_rd_q[i]);
            end
        end
        pend_lsu = (state_q == LSU_WAIT) ? reg_onehot(lsu_rd_q) : '0;
        pend     = (pend_lsu | pend_mul) & ~32'h1;
    end

    assign mul_any = |mul_vld_q;

    // RAW on either source or WAW on the destination against pending writes.
    always_comb begin
        hazard = 1'b0;
        if ((dec_rs1_d != 5'd0) && pend[dec_rs1_d]) begin
            hazard = 1'b1;
        end
        if ((dec_rs2_d != 5'd0) && pend[dec_rs2_d]) begin
            hazard = 1'b1;
        end
        if (dec_wen_d && (dec_rd_d != 5'd0) && pend[dec_rd_d]) begin
            hazard = 1'b1;
        end
    end

    // Per-state issue permission for the op currently in D.
    always_comb begin
        fsm_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (dec_ser_d) begin
                    fsm_ok = ~(|pend) & ~mul_any;
                end else begin
                    fsm_ok = 1'b1;
                end
            end
            LSU_WAIT: begin
`ifdef C7B_ILK_LSU_OVERLAP_EN
                fsm_ok = ~dec_lsu_vld_d & ~dec_ser_d;
`else
                fsm_ok = 1'b0;
`endif
            end
            DRAIN: begin
                fsm_ok = 1'b0;
            end
            default: begin
                fsm_ok = 1'b0;
            end
        endcase
    end

    assign issue = dec_inst_vld_d & ~flush & ~exu_stall & ~hazard & fsm_ok;

    // LSU sequencing FSM, outstanding-load destination and timeout counter.
    always_comb begin
        state_d  = state_q;
        lsu_rd_d = lsu_rd_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (issue && dec_lsu_vld_d) begin
                    state_d  = LSU_WAIT;
                    lsu_rd_d = wr_rd;
                    cnt_d    = '0;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc == TMO_CNT) begin
                    tmo_d = 1'b1;
                end
                if (lsu_ifu_done) begin
`ifdef C7B_ILK_LSU_OVERLAP_EN
                    state_d = IDLE;
`else
                    state_d = DRAIN;
`endif
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // MUL tracking shift register: advances every cycle regardless of stall.
    always_comb begin
        mul_vld_d    = '0;
        mul_rd_d     = '0;
        mul_vld_d[0] = issue & dec_mul_vld_d;
        mul_rd_d[0]  = (issue && dec_mul_vld_d) ? wr_rd : 5'd0;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            mul_vld_d[i] = mul_vld_q[i-1];
            mul_rd_d[i]  = mul_rd_q[i-1];
        end
    end

    // State registers; reset returns to an empty, idle scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lsu_rd_q  <= '0;
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
            mul_vld_q <= '0;
            mul_rd_q  <= '0;
        end else begin
            state_q   <= state_d;
            lsu_rd_q  <= lsu_rd_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            mul_vld_q <= mul_vld_d;
            mul_rd_q  <= mul_rd_d;
        end
    end

    assign ilk_issue   = issue;
    assign ilk_stall   = dec_inst_vld_d & ~issue;
    assign ilk_pend    = pend;
    assign ilk_busy    = (state_q != IDLE) | mul_any;
    assign ilk_lsu_tmo = tmo_q;

endmodule
